perf_sample_sequencer: RTL

Periodic sampling controller for the processor's performance-counter bank. On a programmable interval tick or a software trigger, it snapshots the five live counters (cycle, instruction, stall, branch, SPI transaction) in one cycle. It computes CPI×100 with a multi-cycle sequential divider, then streams a fixed 7-word frame to the debug/trace sink over a valid/ready handshake. It sits between the counter bank and the trace export path.

---
 rtl/perf_pkg.sv | 18 +
 rtl/seq_divider.sv | 76 +++++++
 rtl/perf_sample_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared constants and types for the performance-counter sampling sequencer.
package perf_pkg;

  localparam logic [7:0] FRAME_MAGIC   = 8'hA5;
  localparam int         FRAME_PAYLOAD = 6;
  localparam int         DIV_W         = 39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef logic [2:0] word_idx_t;

  localparam word_idx_t LAST_WORD = 3'(FRAME_PAYLOAD);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, done pulses after DIV_W iterations.
module seq_divider
  import perf_pkg::*;
#(
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DIV_W-1:0] quotient_o
);

  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q;
  logic [5:0]       iter_q, iter_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   rem_sh;
  logic [DVS_W-1:0] rem_sub;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    iter_d  = iter_q;
    run_d   = run_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, quo_q[DIV_W-1]};
    rem_sub = rem_sh[DVS_W-1:0] - dvs_q;
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      iter_d = 6'(DIV_W - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sub;
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DVS_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      if (iter_q == 6'd0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        iter_d = iter_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      iter_q <= iter_d;
      run_q  <= run_d;
      done_q <= done_d;
      if (start_i) dvs_q <= divisor_i;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/perf_sample_sequencer.sv
// Snapshots the perf counters on a timer tick or software trigger, computes CPI x100
// and streams a 7-word frame over valid/ready.
//   state   | meaning
//   IDLE    | waiting for a trigger
//   DIV     | divider computing CPI x100
//   SEND    | frame words streaming to the sink
module perf_sample_sequencer
  import perf_pkg::*;
#(
  parameter int CNT_W            = 32,
  parameter int DEFAULT_INTERVAL = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [31:0]      cfg_interval,
  input  logic             cfg_enable,
  input  logic             sw_trigger,
  input  logic [CNT_W-1:0] cnt_cycle,
  input  logic [CNT_W-1:0] cnt_instr,
  input  logic [CNT_W-1:0] cnt_stall,
  input  logic [CNT_W-1:0] cnt_branch,
  input  logic [CNT_W-1:0] cnt_spi,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      overrun_count
);

  state_e           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      interval_q, interval_d;
  logic [CNT_W-1:0] snap_cycle_q, snap_instr_q, snap_stall_q, snap_branch_q, snap_spi_q;
  logic [CNT_W-1:0] cpi_q, cpi_d;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      ovr_q, ovr_d;
  word_idx_t        idx_q, idx_d, idx_nx;
  logic             valid_q, valid_d, last_q, last_d;
  logic [CNT_W-1:0] data_q, data_d, nxt_word, header;
  logic             tick, trigger, snap_ld, div_start, div_done;
  logic [DIV_W-1:0] quotient;

  seq_divider #(.DVS_W(CNT_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (DIV_W'(cnt_cycle) * DIV_W'(100)),
    .divisor_i  (cnt_instr),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  assign header = {FRAME_MAGIC, 8'(FRAME_PAYLOAD), seq_q};
  assign idx_nx = idx_q + 3'd1;

  always_comb begin
    nxt_word = cpi_q;
    case (idx_nx)
      3'd1:    nxt_word = snap_cycle_q;
      3'd2:    nxt_word = snap_instr_q;
      3'd3:    nxt_word = snap_stall_q;
      3'd4:    nxt_word = snap_branch_q;
      3'd5:    nxt_word = snap_spi_q;
      default: nxt_word = cpi_q;
    endcase
  end

  always_comb begin
    tick       = cfg_enable && (interval_q != 32'd0) && (timer_q == 32'd0);
    trigger    = tick || sw_trigger;
    interval_d = cfg_we ? cfg_interval : interval_q;
    if (cfg_we)          timer_d = cfg_interval - 32'd1;
    else if (tick)       timer_d = interval_q - 32'd1;
    else if (cfg_enable) timer_d = timer_q - 32'd1;
    else                 timer_d = timer_q;

    ovr_d = ovr_q;
    if (trigger && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;

    state_d   = state_q;
    cpi_d     = cpi_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    snap_ld   = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          snap_ld = 1'b1;
          if (cnt_instr != '0) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            cpi_d   = '0;
            state_d = ST_SEND;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          // Quotient above 32 bits saturates rather than wrapping.
          cpi_d   = (|quotient[DIV_W-1:CNT_W]) ? '1 : quotient[CNT_W-1:0];
          state_d = ST_SEND;
          valid_d = 1'b1;
          last_d  = 1'b0;
          idx_d   = '0;
          data_d  = header;
        end
      end
      ST_SEND: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          last_d  = 1'b0;
          idx_d   = '0;
          data_d  = header;
        end else if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            seq_d   = seq_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_nx;
            data_d = nxt_word;
            last_d = (idx_nx == LAST_WORD);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= 32'(DEFAULT_INTERVAL - 1);
      interval_q    <= 32'(DEFAULT_INTERVAL);
      snap_cycle_q  <= '0;
      snap_instr_q  <= '0;
      snap_stall_q  <= '0;
      snap_branch_q <= '0;
      snap_spi_q    <= '0;
      cpi_q         <= '0;
      seq_q         <= '0;
      ovr_q         <= '0;
      idx_q         <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      interval_q <= interval_d;
      cpi_q      <= cpi_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      if (snap_ld) begin
        snap_cycle_q  <= cnt_cycle;
        snap_instr_q  <= cnt_instr;
        snap_stall_q  <= cnt_stall;
        snap_branch_q <= cnt_branch;
        snap_spi_q    <= cnt_spi;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_last      = last_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun_count = ovr_q;

endmodule
